xadac_issue_sched: RTL and testbench

- Issue scheduler for the xadac vector accelerator.
- Accepts decoded xadac instructions (OpT, IdT, vector register indices) from the core-side decoder.
- Resolves RAW/WAW hazards with a per-register scoreboard, then dispatches each instruction to the load unit (Vload) or the compute unit (Vmacc/Vbias/Vactv).
- Collects unit completions and emits one in-order-agnostic retire notification per cycle back to the core.

---
 rtl/xadac_pkg.sv | 55 +++++
 rtl/xadac_issue_sched_if.sv | 69 ++++++
 rtl/xadac_scoreboard.sv | 58 +++++
 rtl/xadac_issue_sched.sv | 174 +++++++++++++++++
 tb/tb_xadac_issue_sched.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_pkg.sv
// Shared xadac types: ops, tags, vreg indices, unit routing.
// Used by the issue scheduler and its scoreboard.
package xadac_pkg;

  localparam int unsigned IdWidth      = 4;
  localparam int unsigned MaxInflight  = 2 ** IdWidth;
  localparam int unsigned NumVregs     = 32;
  localparam int unsigned VregIdxWidth = $clog2(NumVregs);

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [VregIdxWidth-1:0] VregIdxT;

  typedef enum logic [2:0] {
    Null  = 3'd0,
    Vload = 3'd1,
    Vmacc = 3'd2,
    Vbias = 3'd3,
    Vactv = 3'd4
  } OpT;

  typedef enum logic [1:0] {
    UnitNone = 2'd0,
    UnitLd   = 2'd1,
    UnitEx   = 2'd2
  } UnitT;

  typedef enum logic {
    SEmpty = 1'b0,
    SHold  = 1'b1
  } IssStateT;

  typedef struct packed {
    logic    valid;
    VregIdxT vd;
  } IdEntryT;

  function automatic UnitT op_unit(OpT op);
    unique case (op)
      Vload:               return UnitLd;
      Vmacc, Vbias, Vactv: return UnitEx;
      default:             return UnitNone;
    endcase
  endfunction

  // Source reads as {vd, vs2, vs1}; vd counts when accumulated
  function automatic logic [2:0] op_src_mask(OpT op);
    unique case (op)
      Vmacc:   return 3'b111;
      Vbias:   return 3'b101;
      Vactv:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/xadac_issue_sched_if.sv
// Request, dispatch, completion and retire bundle of the
// xadac issue scheduler.
interface xadac_issue_sched_if;
  import xadac_pkg::*;

  logic    req_valid_i;
  logic    req_ready_o;
  OpT      req_op_i;
  IdT      req_id_i;
  VregIdxT req_vd_i;
  VregIdxT req_vs1_i;
  VregIdxT req_vs2_i;

  logic    ld_valid_o;
  logic    ld_ready_i;
  IdT      ld_id_o;
  VregIdxT ld_vd_o;

  logic    ex_valid_o;
  logic    ex_ready_i;
  OpT      ex_op_o;
  IdT      ex_id_o;
  VregIdxT ex_vd_o;
  VregIdxT ex_vs1_o;
  VregIdxT ex_vs2_o;

  logic    ld_done_valid_i;
  logic    ld_done_ready_o;
  IdT      ld_done_id_i;
  logic    ex_done_valid_i;
  logic    ex_done_ready_o;
  IdT      ex_done_id_i;

  logic    retire_valid_o;
  IdT      retire_id_o;

  modport slave (
    input  req_valid_i, req_op_i, req_id_i,
    input  req_vd_i, req_vs1_i, req_vs2_i,
    output req_ready_o,
    output ld_valid_o, ld_id_o, ld_vd_o,
    input  ld_ready_i,
    output ex_valid_o, ex_op_o, ex_id_o,
    output ex_vd_o, ex_vs1_o, ex_vs2_o,
    input  ex_ready_i,
    input  ld_done_valid_i, ld_done_id_i,
    output ld_done_ready_o,
    input  ex_done_valid_i, ex_done_id_i,
    output ex_done_ready_o,
    output retire_valid_o, retire_id_o
  );

  modport master (
    output req_valid_i, req_op_i, req_id_i,
    output req_vd_i, req_vs1_i, req_vs2_i,
    input  req_ready_o,
    input  ld_valid_o, ld_id_o, ld_vd_o,
    output ld_ready_i,
    input  ex_valid_o, ex_op_o, ex_id_o,
    input  ex_vd_o, ex_vs1_o, ex_vs2_o,
    output ex_ready_i,
    output ld_done_valid_i, ld_done_id_i,
    input  ld_done_ready_o,
    output ex_done_valid_i, ex_done_id_i,
    input  ex_done_ready_o,
    input  retire_valid_o, retire_id_o
  );

endinterface

// File: rtl/xadac_scoreboard.sv
// Per-vreg busy bits plus id table of in-flight instructions.
// A set in the same cycle as a clear of the same vreg wins.
module xadac_scoreboard
  import xadac_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    set_i,
  input  IdT      set_id_i,
  input  VregIdxT set_vd_i,
  input  logic    clr_i,
  input  IdT      clr_id_i,
  output logic    clr_hit_o,
  input  IdT      q_id_i,
  input  logic [2:0] q_mask_i,
  input  VregIdxT q_vd_i,
  input  VregIdxT q_vs1_i,
  input  VregIdxT q_vs2_i,
  output logic    hazard_o
);

  logic [NumVregs-1:0]    busy_q, busy_d;
  IdEntryT [MaxInflight-1:0] tbl_q, tbl_d;

  assign clr_hit_o = tbl_q[clr_id_i].valid;

  assign hazard_o = (q_mask_i[0] & busy_q[q_vs1_i])
                  | (q_mask_i[1] & busy_q[q_vs2_i])
                  | (q_mask_i[2] & busy_q[q_vd_i])
                  | tbl_q[q_id_i].valid;

  // Apply completion clear first, then dispatch set
  always_comb begin
    busy_d = busy_q;
    tbl_d  = tbl_q;
    if (clr_i && clr_hit_o) begin
      busy_d[tbl_q[clr_id_i].vd] = 1'b0;
      tbl_d[clr_id_i].valid      = 1'b0;
    end
    if (set_i) begin
      busy_d[set_vd_i]     = 1'b1;
      tbl_d[set_id_i].valid = 1'b1;
      tbl_d[set_id_i].vd    = set_vd_i;
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      tbl_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tbl_q  <= tbl_d;
    end
  end

endmodule

// File: rtl/xadac_issue_sched.sv
// xadac issue scheduler: hazard-checked dispatch and retire.
// Optional perf counters under macro XADAC_SCHED_PERF_EN.
module xadac_issue_sched
  import xadac_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  xadac_issue_sched_if.slave bus
`ifdef XADAC_SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_issued_o
`endif
);

  IssStateT state_q, state_d;
  OpT       op_q, op_d;
  IdT       id_q, id_d;
  VregIdxT  vd_q, vd_d;
  VregIdxT  vs1_q, vs1_d;
  VregIdxT  vs2_q, vs2_d;
  logic     live_q, live_d;
  logic     ret_vld_q, ret_vld_d;
  IdT       ret_id_q, ret_id_d;

  UnitT       unit;
  logic       hold, hazard, null_ret, disp_ok;
  logic       ld_vld, ex_vld, disp, leave, accept;
  logic       ex_acc, ld_acc, comp_acc, comp_hit;
  IdT         comp_id;
  logic [2:0] use_mask;

  assign unit     = op_unit(op_q);
  assign hold     = (state_q == SHold);
  assign use_mask = op_src_mask(op_q)
                  | {(op_q != Null), 2'b00};
  assign null_ret = hold && (unit == UnitNone);
  assign disp_ok  = hold && !hazard && (unit != UnitNone);
  assign ld_vld   = disp_ok && (unit == UnitLd);
  assign ex_vld   = disp_ok && (unit == UnitEx);
  assign disp     = (ld_vld && bus.ld_ready_i)
                  || (ex_vld && bus.ex_ready_i);
  assign leave    = disp || null_ret;
  assign accept   = bus.req_valid_i && bus.req_ready_o;

  assign ex_acc   = bus.ex_done_valid_i && bus.ex_done_ready_o;
  assign ld_acc   = bus.ld_done_valid_i && bus.ld_done_ready_o;
  assign comp_acc = ex_acc || ld_acc;
  assign comp_id  = ex_acc ? bus.ex_done_id_i : bus.ld_done_id_i;

  assign bus.req_ready_o     = live_q && (!hold || leave);
  assign bus.ex_done_ready_o = live_q && !null_ret;
  assign bus.ld_done_ready_o = live_q && !null_ret
                             && !bus.ex_done_valid_i;

  assign bus.ld_valid_o = ld_vld;
  assign bus.ld_id_o    = id_q;
  assign bus.ld_vd_o    = vd_q;
  assign bus.ex_valid_o = ex_vld;
  assign bus.ex_op_o    = op_q;
  assign bus.ex_id_o    = id_q;
  assign bus.ex_vd_o    = vd_q;
  assign bus.ex_vs1_o   = vs1_q;
  assign bus.ex_vs2_o   = vs2_q;

  assign bus.retire_valid_o = ret_vld_q;
  assign bus.retire_id_o    = ret_id_q;

  xadac_scoreboard u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (disp),
    .set_id_i  (id_q),
    .set_vd_i  (vd_q),
    .clr_i     (comp_acc),
    .clr_id_i  (comp_id),
    .clr_hit_o (comp_hit),
    .q_id_i    (id_q),
    .q_mask_i  (use_mask),
    .q_vd_i    (vd_q),
    .q_vs1_i   (vs1_q),
    .q_vs2_i   (vs2_q),
    .hazard_o  (hazard)
  );

  // Issue register next state and retire selection
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    id_d      = id_q;
    vd_d      = vd_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    live_d    = 1'b1;
    ret_vld_d = 1'b0;
    ret_id_d  = '0;
    if (accept) begin
      state_d = SHold;
      op_d    = bus.req_op_i;
      id_d    = bus.req_id_i;
      vd_d    = bus.req_vd_i;
      vs1_d   = bus.req_vs1_i;
      vs2_d   = bus.req_vs2_i;
    end else if (leave) begin
      state_d = SEmpty;
    end
    if (null_ret) begin
      ret_vld_d = 1'b1;
      ret_id_d  = id_q;
    end else if (comp_acc && comp_hit) begin
      ret_vld_d = 1'b1;
      ret_id_d  = comp_id;
    end
  end

  // Issue, liveness and retire registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEmpty;
      op_q      <= Null;
      id_q      <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      live_q    <= 1'b0;
      ret_vld_q <= 1'b0;
      ret_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      id_q      <= id_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      live_q    <= live_d;
      ret_vld_q <= ret_vld_d;
      ret_id_q  <= ret_id_d;
    end
  end

  // A completion must name an instruction that is in flight
  a_comp_known : assert property (
    @(posedge clk_i) disable iff (rst_i)
    comp_acc |-> comp_hit
  );

`ifdef XADAC_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] iss_q, iss_d;

  assign perf_stall_o  = stall_q;
  assign perf_issued_o = iss_q;

  // Count stalled HOLD cycles and dispatch handshakes
  always_comb begin
    stall_d = stall_q;
    iss_d   = iss_q;
    if (hold && !null_ret && !disp) stall_d = stall_q + 32'd1;
    if (disp) iss_d = iss_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      iss_q   <= '0;
    end else begin
      stall_q <= stall_d;
      iss_q   <= iss_d;
    end
  end
`endif

endmodule

// File: tb/tb_xadac_issue_sched.sv
// Directed self-checking bench for xadac_issue_sched.
// Perf checks are included when XADAC_SCHED_PERF_EN is set.
module tb_xadac_issue_sched;
  import xadac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  xadac_issue_sched_if bus ();

`ifdef XADAC_SCHED_PERF_EN
  logic [31:0] perf_stall, perf_issued;
`endif

  xadac_issue_sched dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef XADAC_SCHED_PERF_EN
    ,
    .perf_stall_o  (perf_stall),
    .perf_issued_o (perf_issued)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.req_valid_i     = 1'b0;
    bus.req_op_i        = Null;
    bus.req_id_i        = '0;
    bus.req_vd_i        = '0;
    bus.req_vs1_i       = '0;
    bus.req_vs2_i       = '0;
    bus.ld_ready_i      = 1'b1;
    bus.ex_ready_i      = 1'b1;
    bus.ld_done_valid_i = 1'b0;
    bus.ld_done_id_i    = '0;
    bus.ex_done_valid_i = 1'b0;
    bus.ex_done_id_i    = '0;
  endtask

  task automatic drive_req(input OpT op, input IdT id,
                           input VregIdxT vd, input VregIdxT vs1,
                           input VregIdxT vs2);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_id_i    = id;
    bus.req_vd_i    = vd;
    bus.req_vs1_i   = vs1;
    bus.req_vs2_i   = vs2;
  endtask

  // Accept one request and wait (bounded) for its dispatch
  task automatic issue(input OpT op, input IdT id,
                       input VregIdxT vd, input VregIdxT vs1,
                       input VregIdxT vs2, output bit ok);
    drive_req(op, id, vd, vs1, vs2);
    tick();
    bus.req_valid_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if ((bus.ld_valid_o && bus.ld_ready_i) ||
          (bus.ex_valid_o && bus.ex_ready_i)) ok = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [5:0] v;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    v = {bus.req_ready_o, bus.ld_valid_o, bus.ex_valid_o,
         bus.ld_done_ready_o, bus.ex_done_ready_o,
         bus.retire_valid_o};
    total++;
    if (v !== 6'b0) begin
      bad++;
      $display("FAIL reset_vr got=%b want=000000", v);
    end
    total++;
    if ({bus.ld_id_o, bus.ld_vd_o, bus.ex_id_o, bus.ex_op_o,
         bus.retire_id_o} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0",
               {bus.ld_id_o, bus.ld_vd_o, bus.ex_id_o,
                bus.ex_op_o, bus.retire_id_o});
    end
    tick();
  endtask

  task automatic test_raw();
    drive_req(Vload, 4'd1, 5'd3, 5'd0, 5'd0);
    #1;
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL raw_rdy got=%b want=1", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.ld_valid_o, bus.ld_id_o, bus.ld_vd_o} !==
        {1'b1, 4'd1, 5'd3}) begin
      bad++;
      $display("FAIL raw_ld got=%b/%0d/%0d want=1/1/3",
               bus.ld_valid_o, bus.ld_id_o, bus.ld_vd_o);
    end
    tick();
    drive_req(Vmacc, 4'd2, 5'd4, 5'd3, 5'd5);
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.ex_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL raw_stall%0d got=%b want=0",
                 i, bus.ex_valid_o);
      end
      tick();
    end
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 4'd1;
    tick();
    bus.ld_done_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL raw_ret got=%b/%0d want=1/1",
               bus.retire_valid_o, bus.retire_id_o);
    end
    total++;
    if ({bus.ex_valid_o, bus.ex_op_o, bus.ex_id_o, bus.ex_vd_o,
         bus.ex_vs1_o, bus.ex_vs2_o} !==
        {1'b1, Vmacc, 4'd2, 5'd4, 5'd3, 5'd5}) begin
      bad++;
      $display("FAIL raw_ex got=%b/%0d/%0d/%0d want=1/2/2/4",
               bus.ex_valid_o, bus.ex_op_o, bus.ex_id_o,
               bus.ex_vd_o);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_valid_o, bus.ex_valid_o} !== 2'b00) begin
      bad++;
      $display("FAIL raw_after got=%b%b want=00",
               bus.retire_valid_o, bus.ex_valid_o);
    end
    bus.ex_done_valid_i = 1'b1;
    bus.ex_done_id_i    = 4'd2;
    tick();
    bus.ex_done_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o} !== {1'b1, 4'd2}) begin
      bad++;
      $display("FAIL raw_ret2 got=%b/%0d want=1/2",
               bus.retire_valid_o, bus.retire_id_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    IdT exp_id;
    for (int i = 0; i < 4; i++) begin
      drive_req(Vload, IdT'(i), VregIdxT'(i), 5'd0, 5'd0);
      #1;
      total++;
      if (bus.req_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rdy%0d got=%b want=1", i, bus.req_ready_o);
      end
      if (i > 0) begin
        exp_id = IdT'(i - 1);
        total++;
        if ({bus.ld_valid_o, bus.ld_id_o} !== {1'b1, exp_id}) begin
          bad++;
          $display("FAIL b2b_ld%0d got=%b/%0d want=1/%0d",
                   i, bus.ld_valid_o, bus.ld_id_o, exp_id);
        end
      end
      tick();
    end
    bus.req_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.ld_valid_o, bus.ld_id_o} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL b2b_ld3 got=%b/%0d want=1/3",
               bus.ld_valid_o, bus.ld_id_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.ld_done_valid_i = 1'b1;
      bus.ld_done_id_i    = IdT'(i);
      tick();
      #1;
      exp_id = IdT'(i);
      total++;
      if ({bus.retire_valid_o, bus.retire_id_o} !==
          {1'b1, exp_id}) begin
        bad++;
        $display("FAIL b2b_ret%0d got=%b/%0d want=1/%0d",
                 i, bus.retire_valid_o, bus.retire_id_o, exp_id);
      end
    end
    bus.ld_done_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_simul_done();
    bit ok;
    issue(Vactv, 4'd2, 5'd10, 5'd11, 5'd0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sim_iss_ex got=timeout want=dispatch");
    end
    issue(Vload, 4'd5, 5'd12, 5'd0, 5'd0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sim_iss_ld got=timeout want=dispatch");
    end
    bus.ex_done_valid_i = 1'b1;
    bus.ex_done_id_i    = 4'd2;
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 4'd5;
    #1;
    total++;
    if ({bus.ld_done_ready_o, bus.ex_done_ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL sim_rdy got=%b%b want=01",
               bus.ld_done_ready_o, bus.ex_done_ready_o);
    end
    tick();
    bus.ex_done_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o,
         bus.ld_done_ready_o} !== {1'b1, 4'd2, 1'b1}) begin
      bad++;
      $display("FAIL sim_ret2 got=%b/%0d/%b want=1/2/1",
               bus.retire_valid_o, bus.retire_id_o,
               bus.ld_done_ready_o);
    end
    tick();
    bus.ld_done_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL sim_ret5 got=%b/%0d want=1/5",
               bus.retire_valid_o, bus.retire_id_o);
    end
    tick();
    #1;
    total++;
    if (bus.retire_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL sim_idle got=%b want=0", bus.retire_valid_o);
    end
  endtask

  task automatic test_null();
    drive_req(Null, 4'd7, 5'd9, 5'd0, 5'd0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.ld_valid_o, bus.ex_valid_o, bus.retire_valid_o,
         bus.ex_done_ready_o} !== 4'b0000) begin
      bad++;
      $display("FAIL null_hold got=%b%b%b%b want=0000",
               bus.ld_valid_o, bus.ex_valid_o,
               bus.retire_valid_o, bus.ex_done_ready_o);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o, bus.ld_valid_o,
         bus.ex_valid_o, bus.req_ready_o} !==
        {1'b1, 4'd7, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL null_ret got=%b/%0d/%b%b%b want=1/7/001",
               bus.retire_valid_o, bus.retire_id_o, bus.ld_valid_o,
               bus.ex_valid_o, bus.req_ready_o);
    end
    tick();
    #1;
    total++;
    if (bus.retire_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL null_once got=%b want=0", bus.retire_valid_o);
    end
  endtask

  task automatic test_reissue_reset();
    bit ok;
    logic [5:0] v;
    issue(Vload, 4'd1, 5'd20, 5'd0, 5'd0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rei_iss got=timeout want=dispatch");
    end
    drive_req(Vload, 4'd1, 5'd21, 5'd0, 5'd0);
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.ld_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rei_stall%0d got=%b want=0",
                 i, bus.ld_valid_o);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    v = {bus.req_ready_o, bus.ld_valid_o, bus.ex_valid_o,
         bus.ld_done_ready_o, bus.ex_done_ready_o,
         bus.retire_valid_o};
    total++;
    if (v !== 6'b0 || bus.ld_id_o !== 4'd0 ||
        bus.ld_vd_o !== 5'd0) begin
      bad++;
      $display("FAIL rei_rst got=%b/%0d/%0d want=000000/0/0",
               v, bus.ld_id_o, bus.ld_vd_o);
    end
    tick();
    drive_req(Vactv, 4'd1, 5'd21, 5'd22, 5'd0);
    #1;
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rei_rdy got=%b want=1", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.ex_valid_o, bus.ex_id_o, bus.ex_vd_o} !==
        {1'b1, 4'd1, 5'd21}) begin
      bad++;
      $display("FAIL rei_ex got=%b/%0d/%0d want=1/1/21",
               bus.ex_valid_o, bus.ex_id_o, bus.ex_vd_o);
    end
    tick();
    bus.ex_done_valid_i = 1'b1;
    bus.ex_done_id_i    = 4'd1;
    tick();
    bus.ex_done_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.retire_valid_o, bus.retire_id_o} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL rei_ret got=%b/%0d want=1/1",
               bus.retire_valid_o, bus.retire_id_o);
    end
    tick();
  endtask

`ifdef XADAC_SCHED_PERF_EN
  task automatic test_perf();
    bit ok;
    logic [31:0] s0, i0;
    issue(Vload, 4'd3, 5'd6, 5'd0, 5'd0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL perf_iss got=timeout want=dispatch");
    end
    s0 = perf_stall;
    i0 = perf_issued;
    drive_req(Vbias, 4'd4, 5'd7, 5'd6, 5'd0);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 4'd3;
    tick();
    bus.ld_done_valid_i = 1'b0;
    #1;
    total++;
    if (bus.ex_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL perf_ex got=%b want=1", bus.ex_valid_o);
    end
    tick();
    total++;
    if (perf_stall - s0 !== 32'd3) begin
      bad++;
      $display("FAIL perf_stall got=%0d want=3", perf_stall - s0);
    end
    total++;
    if (perf_issued - i0 !== 32'd1) begin
      bad++;
      $display("FAIL perf_issued got=%0d want=1", perf_issued - i0);
    end
    bus.ex_done_valid_i = 1'b1;
    bus.ex_done_id_i    = 4'd4;
    tick();
    bus.ex_done_valid_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_raw();
    test_back_to_back();
    test_simul_done();
    test_null();
    test_reissue_reset();
`ifdef XADAC_SCHED_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
